listc3r3_matmult_ctrl: RTL and testbench

Initiator/driver for the 3x3 matmult responder (ready/valid/accept protocol). It collects 18 signed 64-bit operand words from an upstream valid/ready stream (A row-major, then B row-major), presents them to the responder, and runs the start/finish/acknowledge handshake. It then streams the 9 result words C row-major to a downstream valid/ready sink. It sits between the host-side data mover and the matmult core.

---
 rtl/listc3r3_matmult_ctrl.sv | 178 +++++++++++++++++
 tb/tb_listc3r3_matmult_ctrl.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/listc3r3_matmult_ctrl.sv
// Driver for the 3x3 matmult responder: gathers A/B operand words from an upstream stream,
// runs the ready/valid/accept handshake, then streams C row-major to a downstream sink.
module listc3r3_matmult_ctrl #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned COLS    = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  out_data,
  output logic         out_last,
  output logic         mm_ready,
  input  logic         mm_valid,
  output logic         mm_accept,
  output logic [575:0] mm_a,
  output logic [575:0] mm_b,
  output logic [7:0]   mm_col,
  input  logic [575:0] mm_c,
  output logic         busy,
  output logic         err
);

  localparam int unsigned     TmoW   = $clog2(TIMEOUT + 1);
  localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT);

  typedef enum logic [1:0] {StLoad, StIssue, StWaitRes, StStream} state_e;

  state_e            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [3:0]        idx_q, idx_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic              err_q, err_d;
  logic [8:0][63:0]  a_q, a_d;
  logic [8:0][63:0]  b_q, b_d;
  logic [8:0][63:0]  c_q, c_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [63:0]       out_data_q, out_data_d;
  logic              mm_ready_q, mm_ready_d;
  logic              mm_accept_q, mm_accept_d;
  logic              busy_q, busy_d;
  logic [3:0]        slot_b;

  assign slot_b = 4'(cnt_q - 5'd9);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    tmo_d       = tmo_q;
    err_d       = err_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    mm_ready_d  = 1'b0;
    mm_accept_d = 1'b0;

    unique case (state_q)
      StLoad: begin
        if (in_valid && in_ready_q) begin
          if (cnt_q < 5'd9) begin
            a_d[cnt_q[3:0]] = in_data;
          end else begin
            b_d[slot_b] = in_data;
          end
          if (cnt_q == 5'd17) begin
            cnt_d      = 5'd0;
            in_ready_d = 1'b0;
            state_d    = StIssue;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      StIssue: begin
        // A valid still high here is the responder's post-accept tail from the last job.
        if (!mm_valid) begin
          mm_ready_d = 1'b1;
          tmo_d      = '0;
          state_d    = StWaitRes;
        end
      end
      StWaitRes: begin
        if (mm_valid) begin
          c_d         = mm_c;
          tmo_d       = '0;
          idx_d       = 4'd0;
          out_data_d  = mm_c[63:0];
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
          mm_accept_d = 1'b1;
          state_d     = StStream;
        end else if (tmo_q != TmoMax) begin
          tmo_d = tmo_q + TmoW'(1);
          if (tmo_d == TmoMax) begin
            err_d = 1'b1;
          end
        end
      end
      StStream: begin
        if (out_ready) begin
          if (idx_q == 4'd8) begin
            idx_d       = 4'd0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = StLoad;
          end else begin
            idx_d      = idx_q + 4'd1;
            out_data_d = c_q[idx_q + 4'd1];
            out_last_d = (idx_q == 4'd7);
          end
        end
      end
      default: state_d = StLoad;
    endcase

    busy_d = !((state_d == StLoad) && (cnt_d == 5'd0));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StLoad;
      cnt_q       <= 5'd0;
      idx_q       <= 4'd0;
      tmo_q       <= '0;
      err_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= 64'd0;
      mm_ready_q  <= 1'b0;
      mm_accept_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      tmo_q       <= tmo_d;
      err_q       <= err_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      mm_ready_q  <= mm_ready_d;
      mm_accept_q <= mm_accept_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign mm_ready  = mm_ready_q;
  assign mm_accept = mm_accept_q;
  assign mm_a      = a_q;
  assign mm_b      = b_q;
  assign mm_col    = 8'(COLS);
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_listc3r3_matmult_ctrl.sv
// Bench for listc3r3_matmult_ctrl: behavioural responder model plus random upstream/downstream
// traffic, with expected results computed as plain matrix products of the submitted jobs.
module tb_listc3r3_matmult_ctrl;

  localparam int unsigned Tmo = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [63:0]  in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [63:0]  out_data;
  logic         out_last;
  logic         mm_ready;
  logic         mm_valid = 1'b0;
  logic         mm_accept;
  logic [575:0] mm_a;
  logic [575:0] mm_b;
  logic [7:0]   mm_col;
  logic [575:0] mm_c = '0;
  logic         busy;
  logic         err;

  listc3r3_matmult_ctrl #(.TIMEOUT(Tmo), .COLS(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .mm_ready(mm_ready), .mm_valid(mm_valid), .mm_accept(mm_accept), .mm_a(mm_a),
    .mm_b(mm_b), .mm_col(mm_col), .mm_c(mm_c), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic signed [63:0] job_a [9];
  logic signed [63:0] job_b [9];
  logic signed [63:0] exp_c [9];

  int rsp_lat     = 3;
  int rsp_hold    = 1;
  bit rsp_release = 1'b0;
  int ready_cnt   = 0;
  int accept_cnt  = 0;

  function automatic logic [575:0] matmul(input logic [575:0] a, input logic [575:0] b);
    logic [575:0]       c;
    logic signed [63:0] acc;
    c = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        acc = 0;
        for (int k = 0; k < 3; k++) begin
          acc += $signed(a[64*(3*i+k) +: 64]) * $signed(b[64*(3*k+j) +: 64]);
        end
        c[64*(3*i+j) +: 64] = acc;
      end
    end
    return c;
  endfunction

  function automatic logic [575:0] pack_a();
    logic [575:0] p;
    for (int i = 0; i < 9; i++) p[64*i +: 64] = job_a[i];
    return p;
  endfunction

  function automatic logic [575:0] pack_b();
    logic [575:0] p;
    for (int i = 0; i < 9; i++) p[64*i +: 64] = job_b[i];
    return p;
  endfunction

  task automatic make_expected();
    logic [575:0] c;
    c = matmul(pack_a(), pack_b());
    for (int i = 0; i < 9; i++) exp_c[i] = c[64*i +: 64];
  endtask

  // Responder model plus pulse monitor; samples DUT outputs mid-cycle, drives just after the edge.
  initial begin : responder
    int st;
    int cnt;
    int hold;
    logic s_ready, s_accept, s_valid, s_rst, prev_ready, prev_accept;
    logic [575:0] s_a, s_b, rsp_c;
    st = 0; cnt = 0; hold = 0; prev_ready = 1'b0; prev_accept = 1'b0; rsp_c = '0;
    forever begin
      @(negedge clk);
      s_ready = mm_ready; s_accept = mm_accept; s_valid = mm_valid; s_rst = rst;
      s_a = mm_a; s_b = mm_b;
      if (mm_ready) begin
        ready_cnt++;
        n_checks++;
        if (prev_ready) $display("FAIL mm_ready_single_cycle: high two cycles, want one");
        else n_pass++;
      end
      if (mm_accept) begin
        accept_cnt++;
        n_checks++;
        if (prev_accept) $display("FAIL mm_accept_single_cycle: high two cycles, want one");
        else n_pass++;
      end
      prev_ready = mm_ready; prev_accept = mm_accept;
      @(posedge clk);
      #1;
      if (!s_rst) begin
        st = 0; mm_valid = 1'b0; mm_c = '0;
      end else begin
        case (st)
          0: if (s_ready) begin
            n_checks++;
            if (s_valid !== 1'b0) $display("FAIL issue_while_valid: mm_valid=%b want 0", s_valid);
            else n_pass++;
            n_checks++;
            if (s_a !== pack_a() || s_b !== pack_b())
              $display("FAIL operands: mm_a/mm_b differ from submitted words, a0=%h b0=%h",
                       s_a[63:0], s_b[63:0]);
            else n_pass++;
            rsp_c = matmul(s_a, s_b);
            cnt = rsp_lat;
            st = 1;
          end
          1: begin
            if ((rsp_lat < 0) ? rsp_release : (cnt <= 1)) begin
              mm_valid = 1'b1; mm_c = rsp_c; st = 2;
            end else if (rsp_lat >= 0) begin
              cnt--;
            end
          end
          2: if (s_accept) begin
            hold = rsp_hold;
            if (hold == 0) begin mm_valid = 1'b0; st = 0; end
            else st = 3;
          end
          default: begin
            hold--;
            if (hold <= 0) begin mm_valid = 1'b0; st = 0; end
          end
        endcase
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_words(input int vprob);
    int sent = 0;
    int cyc = 0;
    bit v, r;
    while (sent < 18 && cyc < 400) begin
      v = ($urandom_range(99) < vprob);
      in_valid = v;
      in_data = (sent < 9) ? job_a[sent] : job_b[sent-9];
      r = in_ready;
      step();
      cyc++;
      if (v && r) sent++;
    end
    in_valid = 1'b0;
    in_data = '0;
    n_checks++;
    if (sent !== 18) $display("FAIL load_count: accepted %0d words want 18", sent);
    else n_pass++;
  endtask

  task automatic drain(input int stall_at, input int stall_len, input int stop_at,
                       input int budget);
    int got = 0;
    int cyc = 0;
    int stall_left = 0;
    int target;
    bit stalled = 1'b0;
    bit r, ov, ol;
    logic [63:0] od;
    target = (stop_at < 0) ? 9 : stop_at;
    while (got < target && cyc < budget) begin
      if (!stalled && got == stall_at && out_valid) begin
        stall_left = stall_len; stalled = 1'b1;
      end
      r = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      out_ready = r;
      ov = out_valid; od = out_data; ol = out_last;
      step();
      cyc++;
      if (ov && r) begin
        n_checks++;
        if (od !== exp_c[got]) $display("FAIL out_data[%0d]: got %h want %h", got, od, exp_c[got]);
        else n_pass++;
        n_checks++;
        if (ol !== (got == 8)) $display("FAIL out_last[%0d]: got %b want %b", got, ol, got == 8);
        else n_pass++;
        got++;
      end else if (ov) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== od || out_last !== ol)
          $display("FAIL stall_hold: v=%b d=%h l=%b want v=1 d=%h l=%b",
                   out_valid, out_data, out_last, od, ol);
        else n_pass++;
      end
    end
    out_ready = 1'b1;
    n_checks++;
    if (got !== target) $display("FAIL drain_count: got %0d beats want %0d", got, target);
    else n_pass++;
  endtask

  task automatic end_checks(input bit exp_err);
    n_checks++;
    if (ready_cnt !== 1) $display("FAIL mm_ready_pulses: got %0d want 1", ready_cnt);
    else n_pass++;
    n_checks++;
    if (accept_cnt !== 1) $display("FAIL mm_accept_pulses: got %0d want 1", accept_cnt);
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL job_done_idle: in_ready=%b out_valid=%b busy=%b want 1 0 0",
               in_ready, out_valid, busy);
    else n_pass++;
    n_checks++;
    if (err !== exp_err) $display("FAIL err_flag: got %b want %b", err, exp_err);
    else n_pass++;
  endtask

  task automatic run_job(input int vprob, input int stall_at, input int stall_len);
    make_expected();
    ready_cnt = 0;
    accept_cnt = 0;
    load_words(vprob);
    n_checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1)
      $display("FAIL loaded_hold_off: in_ready=%b busy=%b want 0 1", in_ready, busy);
    else n_pass++;
    drain(stall_at, stall_len, -1, 300);
  endtask

  task automatic set_seq_job();
    for (int i = 0; i < 9; i++) begin
      job_a[i] = 64'(i + 1);
      job_b[i] = 64'(9 - i);
    end
  endtask

  task automatic set_rand_job();
    for (int i = 0; i < 9; i++) begin
      job_a[i] = ($urandom_range(3) == 0) ? {$urandom(), $urandom()} : 64'($signed($urandom_range(200)) - 100);
      job_b[i] = ($urandom_range(3) == 0) ? {$urandom(), $urandom()} : 64'($signed($urandom_range(200)) - 100);
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #12;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 64'd0)
      $display("FAIL reset_stream: in_ready=%b out_valid=%b out_last=%b out_data=%h",
               in_ready, out_valid, out_last, out_data);
    else n_pass++;
    n_checks++;
    if (mm_ready !== 1'b0 || mm_accept !== 1'b0 || mm_a !== '0 || mm_b !== '0)
      $display("FAIL reset_mm: mm_ready=%b mm_accept=%b a0=%h b0=%h",
               mm_ready, mm_accept, mm_a[63:0], mm_b[63:0]);
    else n_pass++;
    n_checks++;
    if (err !== 1'b0 || busy !== 1'b0 || mm_col !== 8'd3)
      $display("FAIL reset_status: err=%b busy=%b mm_col=%0d want 0 0 3", err, busy, mm_col);
    else n_pass++;
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_basic();
    set_seq_job();
    run_job(100, -1, 0);
    end_checks(1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 9; i++) begin
      job_a[i] = (i % 4 == 0) ? -64'sd1 : 64'sd0;
      job_b[i] = 64'(i + 1);
    end
    for (int j = 0; j < 2; j++) begin
      run_job(100, -1, 0);
      end_checks(1'b0);
    end
  endtask

  task automatic test_stall();
    set_seq_job();
    run_job(50, 4, 3);
    end_checks(1'b0);
  endtask

  task automatic test_random();
    for (int j = 0; j < 4; j++) begin
      set_rand_job();
      run_job($urandom_range(30, 100), $urandom_range(0, 8), $urandom_range(0, 4));
      end_checks(1'b0);
    end
  endtask

  task automatic test_stale_valid();
    int n = 0;
    rsp_hold = 60;
    for (int j = 0; j < 2; j++) begin
      set_rand_job();
      run_job(100, -1, 0);
      end_checks(1'b0);
    end
    rsp_hold = 1;
    while (mm_valid && n < 100) begin step(); n++; end
    n_checks++;
    if (mm_valid !== 1'b0) $display("FAIL stale_drop: mm_valid=%b want 0", mm_valid);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int n = 0;
    set_rand_job();
    make_expected();
    rsp_lat = -1;
    rsp_release = 1'b0;
    ready_cnt = 0;
    accept_cnt = 0;
    load_words(100);
    while (!mm_ready && n < 20) begin step(); n++; end
    n_checks++;
    if (mm_ready !== 1'b1) $display("FAIL timeout_issue: mm_ready=%b want 1", mm_ready);
    else n_pass++;
    repeat (Tmo - 1) step();
    n_checks++;
    if (err !== 1'b0) $display("FAIL err_early: err=%b want 0 after %0d cycles", err, Tmo - 1);
    else n_pass++;
    step();
    n_checks++;
    if (err !== 1'b1) $display("FAIL err_rise: err=%b want 1 after %0d cycles", err, Tmo);
    else n_pass++;
    repeat (20) step();
    n_checks++;
    if (err !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL err_sticky: err=%b out_valid=%b busy=%b want 1 0 1", err, out_valid, busy);
    else n_pass++;
    rsp_release = 1'b1;
    drain(-1, 0, -1, 100);
    end_checks(1'b1);
    rsp_lat = 3;
    rsp_release = 1'b0;
  endtask

  task automatic test_reset_mid();
    set_rand_job();
    make_expected();
    load_words(100);
    drain(-1, 0, 5, 100);
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || err !== 1'b0)
      $display("FAIL async_reset: out_valid=%b in_ready=%b busy=%b err=%b want 0 1 0 0",
               out_valid, in_ready, busy, err);
    else n_pass++;
    n_checks++;
    if (mm_a !== '0 || out_data !== 64'd0)
      $display("FAIL async_reset_data: a0=%h out_data=%h want 0", mm_a[63:0], out_data);
    else n_pass++;
    step();
    step();
    rst = 1'b1;
    step();
    set_rand_job();
    run_job(70, 2, 2);
    end_checks(1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_random();
    test_stale_valid();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
